// File: rtl/hazard_ctrl_if.sv
// Forwarding-select type and the stage-info / pipeline-control bundle that
// connects the pipeline datapath (master) to the hazard controller (slave).
package hazard_pkg;
  typedef enum logic [1:0] {
    HU_REG = 2'd0,
    HU_WB  = 2'd1,
    HU_MEM = 2'd2
  } hu_src_e;
endpackage

interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic                de_valid;
  logic [4:0]          de_rs1, de_rs2;
  logic                ex_valid;
  logic [4:0]          ex_rs1, ex_rs2, ex_rd;
  logic                ex_reg_write, ex_mem_read, ex_mc;
  logic [4:0]          mem_rd;
  logic                mem_reg_write, mem_mem_read;
  logic [4:0]          wb_rd;
  logic                wb_reg_write;
  logic                pc_reset;
  hazard_pkg::hu_src_e rs1s, rs2s;
  logic                stall_f, stall_d, flush_d, bubble_e, stall_e, bubble_m;
  logic                mc_start;
  logic [CNT_W-1:0]    perf_stalls, perf_flushes;

  modport master (
    output de_valid, de_rs1, de_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mc, mem_rd, mem_reg_write,
           mem_mem_read, wb_rd, wb_reg_write, pc_reset,
    input  rs1s, rs2s, stall_f, stall_d, flush_d, bubble_e, stall_e,
           bubble_m, mc_start, perf_stalls, perf_flushes
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, ex_valid, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mc, mem_rd, mem_reg_write,
           mem_mem_read, wb_rd, wb_reg_write, pc_reset,
    output rs1s, rs2s, stall_f, stall_d, flush_d, bubble_e, stall_e,
           bubble_m, mc_start, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: EX operand forwarding,
// load-use stalls, redirect flushes, multi-cycle EX sequencing, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int MC_W = (MC_LAT > 0) ? $clog2(MC_LAT + 1) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_LAT);

  logic [MC_W-1:0]  mc_cnt_reg;
  logic [CNT_W-1:0] perf_stalls_reg, perf_flushes_reg;
  logic             mc_active, mc_busy, load_use;
  logic             stall_f, stall_d, stall_e, flush_d, bubble_e, bubble_m;

  // Per-operand forwarding select and decode load-use hit. Loads in MEM are
  // not forwardable: their data only exists once the instruction reaches WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [4:0] ex_src, de_src;
    hu_src_e    sel;
    logic       de_hit;

    assign ex_src = (gi == 0) ? hz.ex_rs1 : hz.ex_rs2;
    assign de_src = (gi == 0) ? hz.de_rs1 : hz.de_rs2;

    always_comb begin
      sel = HU_REG;
      if (hz.mem_reg_write && !hz.mem_mem_read && hz.mem_rd != 5'd0 &&
          hz.mem_rd == ex_src)
        sel = HU_MEM;
      else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == ex_src)
        sel = HU_WB;
    end

    assign de_hit = hz.de_valid && de_src != 5'd0 &&
                    ((hz.ex_valid && hz.ex_mem_read && hz.ex_reg_write &&
                      hz.ex_rd == de_src) ||
                     (hz.mem_mem_read && hz.mem_reg_write && hz.mem_rd == de_src));
  end

  assign load_use  = g_opnd[0].de_hit || g_opnd[1].de_hit;
  assign mc_active = hz.ex_valid && hz.ex_mc && (MC_LAT != 0);
  assign mc_busy   = mc_active && (mc_cnt_reg != MC_LAST);

  // Redirect wins over everything; the younger instructions are dead anyway.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    bubble_m = 1'b0;
    if (rst_n) begin
      if (hz.pc_reset) begin
        flush_d  = 1'b1;
        bubble_e = 1'b1;
      end else if (mc_busy) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        bubble_m = 1'b1;
      end else if (load_use) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        bubble_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_reg       <= '0;
      perf_stalls_reg  <= '0;
      perf_flushes_reg <= '0;
    end else begin
      mc_cnt_reg       <= mc_busy ? mc_cnt_reg + MC_W'(1) : '0;
      perf_stalls_reg  <= perf_stalls_reg + CNT_W'(stall_f);
      perf_flushes_reg <= perf_flushes_reg + CNT_W'(hz.pc_reset);
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  assign hz.rs1s         = rst_n ? g_opnd[0].sel : HU_REG;
  assign hz.rs2s         = rst_n ? g_opnd[1].sel : HU_REG;
  assign hz.stall_f      = stall_f;
  assign hz.stall_d      = stall_d;
  assign hz.stall_e      = stall_e;
  assign hz.flush_d      = flush_d;
  assign hz.bubble_e     = bubble_e;
  assign hz.bubble_m     = bubble_m;
  assign hz.mc_start     = rst_n && mc_active && (mc_cnt_reg == '0);
  assign hz.perf_stalls  = perf_stalls_reg;
  assign hz.perf_flushes = perf_flushes_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: one MC_LAT=4 instance and one MC_LAT=0
// instance with 2-bit counters for the wrap case.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus0 ();
  hazard_ctrl_if #(.CNT_W(2))  bus1 ();

  hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus0.slave)
  );

  hazard_ctrl #(.MC_LAT(0), .CNT_W(2)) dut_lat0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus1.slave)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus0.pc_reset && bus0.ex_valid && bus0.ex_mc))
        else $error("illegal pc_reset with multi-cycle op in EX (dut)");
      assert (!(bus1.pc_reset && bus1.ex_valid && bus1.ex_mc))
        else $error("illegal pc_reset with multi-cycle op in EX (dut_lat0)");
    end
  end

  task automatic idle_all();
    bus0.de_valid = 0; bus0.de_rs1 = 0; bus0.de_rs2 = 0;
    bus0.ex_valid = 0; bus0.ex_rs1 = 0; bus0.ex_rs2 = 0; bus0.ex_rd = 0;
    bus0.ex_reg_write = 0; bus0.ex_mem_read = 0; bus0.ex_mc = 0;
    bus0.mem_rd = 0; bus0.mem_reg_write = 0; bus0.mem_mem_read = 0;
    bus0.wb_rd = 0; bus0.wb_reg_write = 0; bus0.pc_reset = 0;
    bus1.de_valid = 0; bus1.de_rs1 = 0; bus1.de_rs2 = 0;
    bus1.ex_valid = 0; bus1.ex_rs1 = 0; bus1.ex_rs2 = 0; bus1.ex_rd = 0;
    bus1.ex_reg_write = 0; bus1.ex_mem_read = 0; bus1.ex_mc = 0;
    bus1.mem_rd = 0; bus1.mem_reg_write = 0; bus1.mem_mem_read = 0;
    bus1.wb_rd = 0; bus1.wb_reg_write = 0; bus1.pc_reset = 0;
  endtask

  task automatic apply_reset();
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (bus0.rs1s !== HU_REG || bus0.rs2s !== HU_REG) begin
      errors++; $display("FAIL reset_fwd: rs1s=%0d rs2s=%0d expected 0/0", bus0.rs1s, bus0.rs2s);
    end
    if (bus0.stall_f !== 1'b0 || bus0.stall_d !== 1'b0 || bus0.stall_e !== 1'b0) begin
      errors++; $display("FAIL reset_stalls: f/d/e=%b%b%b expected 000", bus0.stall_f, bus0.stall_d, bus0.stall_e);
    end
    if (bus0.flush_d !== 1'b0 || bus0.bubble_e !== 1'b0 || bus0.bubble_m !== 1'b0) begin
      errors++; $display("FAIL reset_flush: flush_d/bubble_e/bubble_m=%b%b%b expected 000", bus0.flush_d, bus0.bubble_e, bus0.bubble_m);
    end
    if (bus0.mc_start !== 1'b0) begin
      errors++; $display("FAIL reset_mc_start: got %b expected 0", bus0.mc_start);
    end
    if (bus0.perf_stalls !== 32'd0) begin
      errors++; $display("FAIL reset_perf_stalls: got %0d expected 0", bus0.perf_stalls);
    end
    if (bus0.perf_flushes !== 32'd0) begin
      errors++; $display("FAIL reset_perf_flushes: got %0d expected 0", bus0.perf_flushes);
    end
    if (bus1.perf_flushes !== 2'd0 || bus1.perf_stalls !== 2'd0) begin
      errors++; $display("FAIL reset_perf_lat0: stalls=%0d flushes=%0d expected 0/0", bus1.perf_stalls, bus1.perf_flushes);
    end
    $display("test_reset: outputs idle, counters %0d/%0d", bus0.perf_stalls, bus0.perf_flushes);
  endtask

  task automatic test_forwarding();
    hu_src_e exp1 [6];
    hu_src_e exp2 [6];
    exp1 = '{HU_MEM, HU_WB, HU_MEM, HU_REG, HU_WB, HU_REG};
    exp2 = '{HU_REG, HU_REG, HU_REG, HU_REG, HU_REG, HU_MEM};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      idle_all();
      bus0.ex_valid = 1; bus0.ex_rs1 = 5; bus0.ex_rs2 = 6;
      case (c)
        0: begin bus0.mem_rd = 5; bus0.mem_reg_write = 1; end
        1: begin bus0.wb_rd = 5; bus0.wb_reg_write = 1; end
        2: begin bus0.mem_rd = 5; bus0.mem_reg_write = 1; bus0.wb_rd = 5; bus0.wb_reg_write = 1; end
        3: begin bus0.ex_rs1 = 0; bus0.mem_reg_write = 1; bus0.wb_reg_write = 1; end
        4: begin bus0.mem_rd = 5; bus0.mem_reg_write = 1; bus0.mem_mem_read = 1;
                 bus0.wb_rd = 5; bus0.wb_reg_write = 1; end
        default: begin bus0.ex_rs2 = 7; bus0.mem_rd = 7; bus0.mem_reg_write = 1; end
      endcase
      #1;
      checks += 2;
      if (bus0.rs1s !== exp1[c]) begin
        errors++; $display("FAIL fwd_rs1_case%0d: got %0d expected %0d", c, bus0.rs1s, exp1[c]);
      end
      if (bus0.rs2s !== exp2[c]) begin
        errors++; $display("FAIL fwd_rs2_case%0d: got %0d expected %0d", c, bus0.rs2s, exp2[c]);
      end
      $display("test_forwarding: case %0d rs1s=%0d rs2s=%0d", c, bus0.rs1s, bus0.rs2s);
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    bus0.de_valid = 1; bus0.de_rs1 = 3; bus0.de_rs2 = 4;
    bus0.ex_valid = 1; bus0.ex_rd = 3; bus0.ex_mem_read = 1; bus0.ex_reg_write = 1;
    #1;
    checks += 2;
    if ({bus0.stall_f, bus0.stall_d, bus0.bubble_e} !== 3'b111) begin
      errors++; $display("FAIL lu_cycle1: f/d/bubble_e=%b%b%b expected 111", bus0.stall_f, bus0.stall_d, bus0.bubble_e);
    end
    if (bus0.stall_e !== 1'b0 || bus0.flush_d !== 1'b0) begin
      errors++; $display("FAIL lu_cycle1_other: stall_e=%b flush_d=%b expected 0/0", bus0.stall_e, bus0.flush_d);
    end
    $display("test_load_use: cycle 1 stall_f=%b", bus0.stall_f);
    @(negedge clk);
    bus0.ex_valid = 0; bus0.ex_rd = 0; bus0.ex_mem_read = 0; bus0.ex_reg_write = 0;
    bus0.mem_rd = 3; bus0.mem_mem_read = 1; bus0.mem_reg_write = 1;
    #1;
    checks++;
    if ({bus0.stall_f, bus0.stall_d, bus0.bubble_e} !== 3'b111) begin
      errors++; $display("FAIL lu_cycle2: f/d/bubble_e=%b%b%b expected 111", bus0.stall_f, bus0.stall_d, bus0.bubble_e);
    end
    $display("test_load_use: cycle 2 stall_f=%b", bus0.stall_f);
    @(negedge clk);
    bus0.mem_rd = 0; bus0.mem_mem_read = 0; bus0.mem_reg_write = 0;
    bus0.wb_rd = 3; bus0.wb_reg_write = 1;
    #1;
    checks += 2;
    if ({bus0.stall_f, bus0.stall_d, bus0.bubble_e} !== 3'b000) begin
      errors++; $display("FAIL lu_cycle3: f/d/bubble_e=%b%b%b expected 000", bus0.stall_f, bus0.stall_d, bus0.bubble_e);
    end
    if (bus0.perf_stalls !== 32'd2) begin
      errors++; $display("FAIL lu_perf_stalls: got %0d expected 2", bus0.perf_stalls);
    end
    $display("test_load_use: cycle 3 stall_f=%b perf_stalls=%0d", bus0.stall_f, bus0.perf_stalls);
    @(negedge clk);
  endtask

  task automatic test_load_use_gap();
    apply_reset();
    bus0.de_valid = 1; bus0.de_rs1 = 9; bus0.de_rs2 = 3;
    bus0.ex_valid = 1; bus0.ex_rd = 8; bus0.ex_reg_write = 1;
    bus0.mem_rd = 3; bus0.mem_mem_read = 1; bus0.mem_reg_write = 1;
    #1;
    checks++;
    if ({bus0.stall_f, bus0.stall_d, bus0.bubble_e} !== 3'b111) begin
      errors++; $display("FAIL gap_cycle1: f/d/bubble_e=%b%b%b expected 111", bus0.stall_f, bus0.stall_d, bus0.bubble_e);
    end
    $display("test_load_use_gap: cycle 1 stall_f=%b", bus0.stall_f);
    @(negedge clk);
    bus0.ex_valid = 0; bus0.ex_rd = 0; bus0.ex_reg_write = 0;
    bus0.mem_rd = 8; bus0.mem_mem_read = 0; bus0.mem_reg_write = 1;
    bus0.wb_rd = 3; bus0.wb_reg_write = 1;
    #1;
    checks += 2;
    if (bus0.stall_f !== 1'b0) begin
      errors++; $display("FAIL gap_cycle2: stall_f=%b expected 0", bus0.stall_f);
    end
    if (bus0.perf_stalls !== 32'd1) begin
      errors++; $display("FAIL gap_perf_stalls: got %0d expected 1", bus0.perf_stalls);
    end
    $display("test_load_use_gap: cycle 2 stall_f=%b perf_stalls=%0d", bus0.stall_f, bus0.perf_stalls);
    @(negedge clk);
  endtask

  task automatic test_redirect();
    apply_reset();
    bus0.de_valid = 1; bus0.de_rs1 = 3;
    bus0.ex_valid = 1; bus0.ex_rd = 3; bus0.ex_mem_read = 1; bus0.ex_reg_write = 1;
    bus0.pc_reset = 1;
    #1;
    checks += 3;
    if (bus0.flush_d !== 1'b1 || bus0.bubble_e !== 1'b1) begin
      errors++; $display("FAIL redir_flush: flush_d=%b bubble_e=%b expected 1/1", bus0.flush_d, bus0.bubble_e);
    end
    if (bus0.stall_f !== 1'b0 || bus0.stall_d !== 1'b0) begin
      errors++; $display("FAIL redir_stalls: stall_f=%b stall_d=%b expected 0/0", bus0.stall_f, bus0.stall_d);
    end
    if (bus0.perf_flushes !== 32'd0) begin
      errors++; $display("FAIL redir_perf_before: got %0d expected 0", bus0.perf_flushes);
    end
    $display("test_redirect: flush_d=%b stall_f=%b", bus0.flush_d, bus0.stall_f);
    @(negedge clk);
    idle_all();
    #1;
    checks += 2;
    if (bus0.perf_flushes !== 32'd1) begin
      errors++; $display("FAIL redir_perf_after: got %0d expected 1", bus0.perf_flushes);
    end
    if (bus0.perf_stalls !== 32'd0) begin
      errors++; $display("FAIL redir_perf_stalls: got %0d expected 0", bus0.perf_stalls);
    end
    $display("test_redirect: perf_flushes=%0d", bus0.perf_flushes);
    @(negedge clk);
  endtask

  // Holds a multi-cycle op in EX for n cycles; a new op enters every 5 cycles.
  task automatic run_mc(input int n, input int exp_stalls, input string tag);
    apply_reset();
    for (int c = 0; c < n; c++) begin
      logic exp_start, exp_stall;
      bus0.ex_valid = 1; bus0.ex_mc = 1; bus0.ex_rd = 10; bus0.ex_reg_write = 1;
      exp_start = ((c % 5) == 0);
      exp_stall = ((c % 5) != 4);
      #1;
      checks += 2;
      if (bus0.mc_start !== exp_start) begin
        errors++; $display("FAIL %s_mc_start_c%0d: got %b expected %b", tag, c + 1, bus0.mc_start, exp_start);
      end
      if ({bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.bubble_m} !== {4{exp_stall}}) begin
        errors++; $display("FAIL %s_stall_c%0d: f/d/e/bm=%b%b%b%b expected %b", tag, c + 1,
                           bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.bubble_m, exp_stall);
      end
      $display("%s: cycle %0d mc_start=%b stall_f=%b", tag, c + 1, bus0.mc_start, bus0.stall_f);
      @(negedge clk);
    end
    idle_all();
    #1;
    checks++;
    if (bus0.perf_stalls !== 32'(exp_stalls)) begin
      errors++; $display("FAIL %s_perf_stalls: got %0d expected %0d", tag, bus0.perf_stalls, exp_stalls);
    end
    @(negedge clk);
  endtask

  task automatic test_multicycle();
    run_mc(5, 4, "test_multicycle");
  endtask

  task automatic test_back_to_back();
    run_mc(10, 8, "test_back_to_back");
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    bus0.ex_valid = 1; bus0.ex_mc = 1; bus0.ex_rs1 = 5;
    @(negedge clk);
    bus0.mem_rd = 5; bus0.mem_reg_write = 1;
    #1;
    checks++;
    if (bus0.stall_f !== 1'b1 || bus0.rs1s !== HU_MEM) begin
      errors++; $display("FAIL rmid_pre: stall_f=%b rs1s=%0d expected 1/2", bus0.stall_f, bus0.rs1s);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if ({bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.bubble_m, bus0.mc_start} !== 5'b0) begin
      errors++; $display("FAIL rmid_outputs: f/d/e/bm/start=%b%b%b%b%b expected 00000",
                         bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.bubble_m, bus0.mc_start);
    end
    if (bus0.rs1s !== HU_REG) begin
      errors++; $display("FAIL rmid_rs1s: got %0d expected 0", bus0.rs1s);
    end
    if (bus0.perf_stalls !== 32'd0) begin
      errors++; $display("FAIL rmid_perf_stalls: got %0d expected 0", bus0.perf_stalls);
    end
    $display("test_reset_mid_op: in reset stall_f=%b perf_stalls=%0d", bus0.stall_f, bus0.perf_stalls);
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus0.stall_f !== 1'b0 || bus0.mc_start !== 1'b0) begin
      errors++; $display("FAIL rmid_idle: stall_f=%b mc_start=%b expected 0/0", bus0.stall_f, bus0.mc_start);
    end
    @(negedge clk);
    bus0.ex_valid = 1; bus0.ex_mc = 1;
    #1;
    checks++;
    if (bus0.mc_start !== 1'b1 || bus0.stall_f !== 1'b1) begin
      errors++; $display("FAIL rmid_restart: mc_start=%b stall_f=%b expected 1/1", bus0.mc_start, bus0.stall_f);
    end
    $display("test_reset_mid_op: new op mc_start=%b", bus0.mc_start);
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_mc_lat0();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      bus1.ex_valid = 1; bus1.ex_mc = 1;
      #1;
      checks++;
      if ({bus1.stall_f, bus1.stall_e, bus1.bubble_m, bus1.mc_start} !== 4'b0) begin
        errors++; $display("FAIL lat0_c%0d: f/e/bm/start=%b%b%b%b expected 0000", c + 1,
                           bus1.stall_f, bus1.stall_e, bus1.bubble_m, bus1.mc_start);
      end
      $display("test_mc_lat0: cycle %0d stall_f=%b mc_start=%b", c + 1, bus1.stall_f, bus1.mc_start);
      @(negedge clk);
    end
    idle_all();
    for (int c = 0; c < 5; c++) begin
      bus1.pc_reset = 1;
      @(negedge clk);
    end
    idle_all();
    #1;
    checks++;
    if (bus1.perf_flushes !== 2'd1) begin
      errors++; $display("FAIL lat0_flush_wrap: got %0d expected 1", bus1.perf_flushes);
    end
    $display("test_mc_lat0: perf_flushes after 5 redirects (2-bit) = %0d", bus1.perf_flushes);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_load_use_gap();
    test_redirect();
    test_multicycle();
    test_back_to_back();
    test_reset_mid_op();
    test_mc_lat0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
